dla_tile_sched: RTL and testbench

Tile scheduler for the DLA input-feature-map ping-pong buffers.
- Software or DMA fills one IFM bank through the DLA bus wrapper while the compute engine runs on the other bank.
- The block tracks ownership of ifm0/ifm1, dispatches compute jobs, counts tiles and raises a completion interrupt.
- It sits between the wrapper's config-write strobes and the DLA engine's start/done handshake.

---
 rtl/dla_tile_sched.sv | 150 +++++++++++++++
 tb/tb_dla_tile_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dla_tile_sched.sv
// dla_tile_sched: ownership tracker for the ping-pong IFM banks. It accepts fills over config
// writes, dispatches compute jobs to the engine, counts tiles and raises a completion interrupt.
module dla_tile_sched #(
  parameter int TILE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cfg_w_en,
  input  logic [31:0] cfg_w_data,
  input  logic        comp_done,
  output logic        fill_ready,
  output logic        fill_buf,
  output logic        comp_start,
  output logic        comp_buf,
  output logic        busy,
  output logic        dla_idle,
  output logic        irq,
  output logic [31:0] status
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] BK_EMPTY = 2'd0;
  localparam logic [1:0] BK_FULL  = 2'd1;
  localparam logic [1:0] BK_COMP  = 2'd2;

  logic [1:0]        state;
  logic [1:0][1:0]   bank;
  logic              fill_ptr;
  logic              comp_ptr;
  logic [TILE_W-1:0] tiles_filled;
  logic [TILE_W-1:0] tiles_done;
  logic [TILE_W-1:0] tile_num;
  logic              irq_en;
  logic              err;
  logic              comp_start_q;
  logic              comp_buf_q;

  logic              ctrl_wr;
  logic              start_wr;
  logic              irq_clr;
  logic              abort_wr;
  logic              tiles_wr;
  logic              fill_wr;
  logic              fill_ok;
  logic              comp_active;
  logic              done_ok;
  logic              last_tile;
  logic              disp_ptr;
  logic              dispatch;
  logic [TILE_W-1:0] tiles_done_inc;
  logic              unused_data;

  assign ctrl_wr  = cfg_w_en[0];
  assign start_wr = ctrl_wr & cfg_w_data[0];
  assign irq_clr  = ctrl_wr & cfg_w_data[2];
  assign abort_wr = ctrl_wr & cfg_w_data[3];
  assign tiles_wr = cfg_w_en[1];
  assign fill_wr  = cfg_w_en[2] & cfg_w_data[0];
  assign unused_data = ^cfg_w_data[31:TILE_W];

  assign fill_ok        = (state == ST_RUN) && (bank[fill_ptr] == BK_EMPTY) && (tiles_filled < tile_num);
  assign comp_active    = (bank[0] == BK_COMP) || (bank[1] == BK_COMP);
  assign done_ok        = comp_done && comp_active;
  assign tiles_done_inc = tiles_done + TILE_W'(1);
  assign last_tile      = done_ok && (tiles_done_inc == tile_num);

  // The job in flight always lives in bank[comp_ptr]; a finishing job hands dispatch to the other bank
  // on the same edge, using the pre-edge bank state so a freshly filled bank waits one cycle.
  assign disp_ptr = done_ok ? ~comp_ptr : comp_ptr;
  assign dispatch = (state == ST_RUN) && !last_tile && (!comp_active || done_ok) &&
                    (bank[disp_ptr] == BK_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bank         <= {BK_EMPTY, BK_EMPTY};
      fill_ptr     <= 1'b0;
      comp_ptr     <= 1'b0;
      tiles_filled <= '0;
      tiles_done   <= '0;
      tile_num     <= '0;
      irq_en       <= 1'b0;
      err          <= 1'b0;
      comp_start_q <= 1'b0;
      comp_buf_q   <= 1'b0;
    end else begin
      comp_start_q <= 1'b0;
      if (ctrl_wr) irq_en <= cfg_w_data[1];
      if (tiles_wr && state != ST_RUN) tile_num <= cfg_w_data[TILE_W-1:0];

      if (abort_wr) begin
        // Counters are kept so software can read back how far the job got.
        state    <= ST_IDLE;
        bank     <= {BK_EMPTY, BK_EMPTY};
        fill_ptr <= 1'b0;
        comp_ptr <= 1'b0;
      end else if (start_wr && state != ST_RUN) begin
        state        <= (tile_num != '0) ? ST_RUN : ST_DONE;
        bank         <= {BK_EMPTY, BK_EMPTY};
        fill_ptr     <= 1'b0;
        comp_ptr     <= 1'b0;
        tiles_filled <= '0;
        tiles_done   <= '0;
        err          <= 1'b0;
      end else begin
        if (state == ST_DONE && irq_clr) state <= ST_IDLE;

        if (fill_wr) begin
          if (fill_ok) begin
            bank[fill_ptr] <= BK_FULL;
            fill_ptr       <= ~fill_ptr;
            tiles_filled   <= tiles_filled + TILE_W'(1);
          end else begin
            err <= 1'b1;
          end
        end

        if (comp_done) begin
          if (comp_active) begin
            bank[comp_ptr] <= BK_EMPTY;
            comp_ptr       <= ~comp_ptr;
            tiles_done     <= tiles_done_inc;
            if (last_tile) state <= ST_DONE;
          end else begin
            err <= 1'b1;
          end
        end

        if (dispatch) begin
          comp_start_q   <= 1'b1;
          comp_buf_q     <= disp_ptr;
          bank[disp_ptr] <= BK_COMP;
        end
      end
    end
  end

  assign fill_ready = fill_ok;
  assign fill_buf   = fill_ptr;
  assign comp_start = comp_start_q;
  assign comp_buf   = comp_buf_q;
  assign busy       = (state == ST_RUN);
  assign dla_idle   = ~busy;
  assign irq        = (state == ST_DONE) && irq_en;
  assign status     = {16'(tiles_done), 12'b0, err, irq, (state == ST_DONE), busy};

endmodule

// File: tb/tb_dla_tile_sched.sv
// Bench for dla_tile_sched: directed scenarios plus random traffic, all checked every cycle
// against a bank/counter reference model of the scheduling rules.
module tb_dla_tile_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cfg_w_en;
  logic [31:0] cfg_w_data;
  logic        comp_done;
  logic        fill_ready;
  logic        fill_buf;
  logic        comp_start;
  logic        comp_buf;
  logic        busy;
  logic        dla_idle;
  logic        irq;
  logic [31:0] status;

  always #5 clk = ~clk;

  dla_tile_sched #(.TILE_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_w_en   (cfg_w_en),
    .cfg_w_data (cfg_w_data),
    .comp_done  (comp_done),
    .fill_ready (fill_ready),
    .fill_buf   (fill_buf),
    .comp_start (comp_start),
    .comp_buf   (comp_buf),
    .busy       (busy),
    .dla_idle   (dla_idle),
    .irq        (irq),
    .status     (status)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: state 0=idle 1=run 2=done; bank 0=empty 1=full 2=computing.
  int m_st;
  int m_bank[2];
  int m_fptr, m_cptr, m_filled, m_done, m_tnum, m_cbuf;
  bit m_irqen, m_err, m_cstart;

  int eng_busy = 0;
  int eng_cnt  = 0;

  task automatic model_reset();
    m_st = 0; m_bank[0] = 0; m_bank[1] = 0;
    m_fptr = 0; m_cptr = 0; m_filled = 0; m_done = 0; m_tnum = 0; m_cbuf = 0;
    m_irqen = 0; m_err = 0; m_cstart = 0;
  endtask

  function automatic bit exp_fill_ready();
    return (m_st == 1) && (m_bank[m_fptr] == 0) && (m_filled < m_tnum);
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    logic [31:0] dn;
    dn = 32'(m_done);
    s = {dn[15:0], 12'b0, m_err, (m_st == 2) && m_irqen, m_st == 2, m_st == 1};
    return s;
  endfunction

  task automatic model_step();
    logic [31:0] d;
    bit ctrl, start, clr, abort, fill, can_fill;
    int old_bank[2];
    int active;
    d = cfg_w_data;
    ctrl = cfg_w_en[0];
    start = ctrl && d[0];
    clr = ctrl && d[2];
    abort = ctrl && d[3];
    fill = cfg_w_en[2] && d[0];
    can_fill = exp_fill_ready();
    old_bank = m_bank;
    active = -1;
    m_cstart = 0;
    if (ctrl) m_irqen = d[1];
    if (cfg_w_en[1] && m_st != 1) m_tnum = int'(d[15:0]);
    if (abort) begin
      m_st = 0; m_bank[0] = 0; m_bank[1] = 0; m_fptr = 0; m_cptr = 0;
    end else if (start && m_st != 1) begin
      m_st = (m_tnum != 0) ? 1 : 2;
      m_bank[0] = 0; m_bank[1] = 0; m_fptr = 0; m_cptr = 0;
      m_filled = 0; m_done = 0; m_err = 0;
    end else begin
      if (m_st == 2 && clr) m_st = 0;
      for (int b = 0; b < 2; b++) if (m_bank[b] == 2) active = b;
      if (fill) begin
        if (can_fill) begin
          m_bank[m_fptr] = 1; m_fptr = 1 - m_fptr; m_filled++;
        end else m_err = 1;
      end
      if (comp_done) begin
        if (active >= 0) begin
          m_bank[active] = 0; m_cptr = 1 - active; m_done++;
          if (m_done == m_tnum) m_st = 2;
        end else m_err = 1;
      end
      if (m_st == 1 && m_bank[0] != 2 && m_bank[1] != 2 && old_bank[m_cptr] == 1) begin
        m_cstart = 1; m_cbuf = m_cptr; m_bank[m_cptr] = 2;
      end
    end
  endtask

  task automatic check_all();
    chk("fill_ready", 32'(fill_ready), 32'(exp_fill_ready()));
    chk("fill_buf",   32'(fill_buf),   32'(m_fptr));
    chk("comp_start", 32'(comp_start), 32'(m_cstart));
    chk("comp_buf",   32'(comp_buf),   32'(m_cbuf));
    chk("busy",       32'(busy),       32'(m_st == 1));
    chk("dla_idle",   32'(dla_idle),   32'(m_st != 1));
    chk("irq",        32'(irq),        32'((m_st == 2) && m_irqen));
    chk("status",     status,          exp_status());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (comp_start) begin eng_busy = 1; eng_cnt = $urandom_range(0, 3); end
    @(negedge clk);
    cfg_w_en = 3'b000; cfg_w_data = 32'h0; comp_done = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] data);
    cfg_w_en = 3'b001 << idx;
    cfg_w_data = data;
    tick();
  endtask

  task automatic engine_drive();
    if (eng_busy != 0) begin
      if (eng_cnt == 0) begin comp_done = 1'b1; eng_busy = 0; end
      else eng_cnt--;
    end
  endtask

  int bufs[$];

  initial begin
    rst_n = 1'b0; cfg_w_en = 3'b000; cfg_w_data = 32'h0; comp_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_fill_ready", 32'(fill_ready), 0);
    chk("rst_fill_buf",   32'(fill_buf), 0);
    chk("rst_comp_start", 32'(comp_start), 0);
    chk("rst_comp_buf",   32'(comp_buf), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_dla_idle",   32'(dla_idle), 1);
    chk("rst_irq",        32'(irq), 0);
    chk("rst_status",     status, 32'h0);
    rst_n = 1'b1;
    tick(); tick();

    // single tile
    wr(1, 32'd1);
    wr(0, 32'h3);
    chk("st_busy", 32'(busy), 1);
    chk("st_fill_ready", 32'(fill_ready), 1);
    wr(2, 32'h1);
    tick();
    chk("st_cstart", 32'(comp_start), 1);
    chk("st_cbuf", 32'(comp_buf), 0);
    tick();
    chk("st_cstart_pulse", 32'(comp_start), 0);
    comp_done = 1'b1;
    tick();
    chk("st_status", status, 32'h0001_0006);
    chk("st_irq", 32'(irq), 1);
    wr(0, 32'h4);
    chk("st_irq_clr", 32'(irq), 0);
    chk("st_idle_status", status, 32'h0001_0000);

    // ping-pong over four tiles
    wr(1, 32'd4);
    wr(0, 32'h1);
    wr(2, 32'h1);
    wr(2, 32'h1);
    chk("pp_cstart0", 32'(comp_start), 1);
    chk("pp_cbuf0", 32'(comp_buf), 0);
    bufs.delete();
    bufs.push_back(int'(comp_buf));
    eng_busy = 0;
    tick();
    chk("pp_fr_hold0", 32'(fill_ready), 0);
    tick();
    chk("pp_fr_hold1", 32'(fill_ready), 0);
    comp_done = 1'b1;
    tick();
    chk("pp_cstart1", 32'(comp_start), 1);
    chk("pp_cbuf1", 32'(comp_buf), 1);
    chk("pp_fr_after", 32'(fill_ready), 1);
    bufs.push_back(int'(comp_buf));
    for (int c = 0; c < 80 && m_st == 1; c++) begin
      if (exp_fill_ready()) begin cfg_w_en = 3'b100; cfg_w_data = 32'h1; end
      engine_drive();
      tick();
      if (comp_start) bufs.push_back(int'(comp_buf));
    end
    chk("pp_finished", 32'(busy), 0);
    chk("pp_jobs", 32'(bufs.size()), 4);
    for (int i = 0; i < bufs.size() && i < 4; i++) chk("pp_order", 32'(bufs[i]), 32'(i % 2));
    chk("pp_tiles_done", {16'h0, status[31:16]}, 32'd4);
    wr(0, 32'h4);

    // FILL and comp_done on the same edge
    wr(1, 32'd2);
    wr(0, 32'h1);
    wr(2, 32'h1);
    tick();
    chk("sim_cstart0", 32'(comp_start), 1);
    comp_done = 1'b1;
    wr(2, 32'h1);
    chk("sim_no_early_dispatch", 32'(comp_start), 0);
    chk("sim_tiles_done", {16'h0, status[31:16]}, 32'd1);
    tick();
    chk("sim_cstart1", 32'(comp_start), 1);
    chk("sim_cbuf1", 32'(comp_buf), 1);
    comp_done = 1'b1;
    tick();
    chk("sim_done_noirq", status[3:0], 32'h2);
    wr(0, 32'h4);

    // error cases
    comp_done = 1'b1;
    tick();
    chk("err_spurious_done", 32'(status[3]), 1);
    chk("err_counters_kept", {16'h0, status[31:16]}, 32'd2);
    wr(1, 32'd1);
    wr(0, 32'h1);
    chk("err_cleared", 32'(status[3]), 0);
    wr(2, 32'h1);
    wr(2, 32'h1);
    chk("err_bad_fill", 32'(status[3]), 1);
    chk("err_dispatch_kept", 32'(comp_start), 1);
    comp_done = 1'b1;
    tick();
    wr(0, 32'h4);

    // abort with start mid-run
    wr(1, 32'd3);
    wr(0, 32'h1);
    wr(2, 32'h1);
    wr(0, 32'h9);
    chk("ab_no_cstart", 32'(comp_start), 0);
    chk("ab_busy", 32'(busy), 0);
    tick();
    chk("ab_no_cstart_late", 32'(comp_start), 0);

    // zero-tile start goes straight to DONE
    wr(1, 32'd0);
    wr(0, 32'h3);
    chk("z_flags_irq", status[2:0], 32'h6);
    wr(0, 32'h1);
    chk("z_flags_noirq", status[2:0], 32'h2);
    wr(0, 32'h4);

    // asynchronous reset mid-run
    wr(1, 32'd2);
    wr(0, 32'h3);
    wr(2, 32'h1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_fill_ready", 32'(fill_ready), 0);
    chk("ar_fill_buf", 32'(fill_buf), 0);
    chk("ar_comp_start", 32'(comp_start), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_dla_idle", 32'(dla_idle), 1);
    chk("ar_status", status, 32'h0);
    model_reset();
    eng_busy = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // random traffic
    for (int it = 0; it < 3000; it++) begin
      int r;
      bit fr;
      r = $urandom_range(0, 99);
      fr = exp_fill_ready();
      if (m_st != 1) begin
        if (r < 30) begin
          cfg_w_en = 3'b001; cfg_w_data = $urandom & 32'hFFFF_FFF0;
          cfg_w_data[0] = 1'b1; cfg_w_data[1] = 1'($urandom_range(0, 1)); cfg_w_data[2] = 1'($urandom_range(0, 1));
        end else if (r < 50) begin
          cfg_w_en = 3'b010; cfg_w_data = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 5));
        end else if (r < 55) begin
          cfg_w_en = 3'b001; cfg_w_data = 32'h4; cfg_w_data[1] = 1'($urandom_range(0, 1));
        end else if (r < 58) begin
          cfg_w_en = 3'b100; cfg_w_data = $urandom | 32'h1;
        end
      end else begin
        if (r < 2) begin
          cfg_w_en = 3'b001; cfg_w_data = 32'h8 | 32'($urandom_range(0, 7));
        end else if (r < 4) begin
          cfg_w_en = 3'b001; cfg_w_data = 32'h1; cfg_w_data[1] = 1'($urandom_range(0, 1));
        end else if (r < 5) begin
          cfg_w_en = 3'b010; cfg_w_data = 32'($urandom_range(0, 5));
        end else if (r < 65 && fr) begin
          cfg_w_en = 3'b100; cfg_w_data = $urandom | 32'h1;
        end else if (r < 68) begin
          cfg_w_en = 3'b100; cfg_w_data = $urandom;
        end
      end
      engine_drive();
      if (eng_busy == 0 && !comp_done && $urandom_range(0, 59) == 0) comp_done = 1'b1;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
